// File: rtl/sample_ingress_if.sv
// Strobe/sample inputs plus the show-ahead valid/ready drain port of sample_ingress.
// slave = ingress stage side, master = producer/detector side.
interface sample_ingress_if #(
  parameter int DATA_W = 16
);
  logic              new_number;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;

  modport slave (
    input  new_number, x, y, out_ready,
    output out_valid, out_x, out_y
  );

  modport master (
    output new_number, x, y, out_ready,
    input  out_valid, out_x, out_y
  );
endinterface

// File: rtl/sample_ingress.sv
// sample_ingress: one capture per new_number rising edge into a show-ahead FIFO; push lands SYNC_STAGES+1 edges after the strobe.
// Drained via out_valid/out_ready; a capture into a full FIFO without a same-cycle pop is dropped and sets overflow.
// Optional duplicate-x filter: define SAMPLE_INGRESS_DUP_FILTER_EN.
module sample_ingress #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  sample_ingress_if.slave          bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic [15:0]              sample_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_sync_out;
  logic                   w_cap;
  logic                   w_cand;

  logic [DATA_W-1:0]      r_mem_x [DEPTH];
  logic [DATA_W-1:0]      r_mem_y [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;
  logic                   r_valid;
  logic                   r_ovf;
  logic [15:0]            r_count;
  logic [DATA_W-1:0]      r_out_x;
  logic [DATA_W-1:0]      r_out_y;

  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [PTR_W-1:0]       w_rd_nxt;
  logic [LVL_W-1:0]       w_level_nxt;
  logic                   w_push_is_head;
  logic [DATA_W-1:0]      w_out_x_nxt;
  logic [DATA_W-1:0]      w_out_y_nxt;

  // Chain and edge flop reset to 1 so a strobe already high at reset release is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_edge <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.new_number};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_cap      = w_sync_out & ~r_edge;

`ifdef SAMPLE_INGRESS_DUP_FILTER_EN
  logic              r_last_valid;
  logic [DATA_W-1:0] r_last_x;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_valid <= 1'b0;
      r_last_x     <= '0;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last_x     <= bus.x;
    end
  end

  // Repeat of the last accepted x vanishes before the full check: no push, count or overflow.
  assign w_cand = w_cap & ~(r_last_valid & (bus.x == r_last_x));
`else
  assign w_cand = w_cap;
`endif

  assign w_full = (r_level == FULL_LVL);
  assign w_pop  = r_valid & bus.out_ready;
  assign w_push = w_cand & (~w_full | w_pop);
  assign w_drop = w_cand & ~w_push;

  assign w_rd_nxt       = r_rd_ptr + PTR_W'(w_pop);
  assign w_push_is_head = w_push & ((r_level - LVL_W'(w_pop)) == '0);

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Head is registered so it holds the last popped value once the FIFO empties.
  always_comb begin
    w_out_x_nxt = r_out_x;
    w_out_y_nxt = r_out_y;
    if (w_level_nxt != '0) begin
      if (w_push_is_head) begin
        w_out_x_nxt = bus.x;
        w_out_y_nxt = bus.y;
      end else begin
        w_out_x_nxt = r_mem_x[w_rd_nxt];
        w_out_y_nxt = r_mem_y[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_x[i] <= '0;
        r_mem_y[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_out_x  <= '0;
      r_out_y  <= '0;
    end else begin
      if (w_push) begin
        r_mem_x[r_wr_ptr] <= bus.x;
        r_mem_y[r_wr_ptr] <= bus.y;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_valid  <= (w_level_nxt != '0);
      r_out_x  <= w_out_x_nxt;
      r_out_y  <= w_out_y_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_push) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
  assign fifo_level    = r_level;
  assign overflow      = r_ovf;
  assign sample_count  = r_count;

endmodule

// File: tb/tb_sample_ingress.sv
// Directed bench for sample_ingress: expected heads queued at stimulus time, checked by a pop monitor.
module tb_sample_ingress;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } smp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_ovf;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] sample_count;

  smp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] t3x [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
  logic [15:0] t3y [5] = '{16'd5, 16'd10, 16'd17, 16'd20, 16'd24};

  sample_ingress_if #(.DATA_W(16)) bus ();

  sample_ingress #(
    .DATA_W(16),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .clear_ovf(clear_ovf),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pop monitor: every accepted head must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got x=%0d y=%0d expected no head", bus.out_x, bus.out_y);
        end else begin
          smp_t e;
          e = sb.pop_front();
          chk("head_x", 32'(bus.out_x), 32'(e.x));
          chk("head_y", 32'(bus.out_y), 32'(e.y));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic reset_dut();
    reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic strobe(input logic [15:0] sx, input logic [15:0] sy, input bit accept);
    @(posedge clk);
    #1;
    bus.x = sx;
    bus.y = sy;
    bus.new_number = 1'b1;
    if (accept) sb.push_back('{x: sx, y: sy});
    repeat (4) @(posedge clk);
    #1 bus.new_number = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic drain(input int n_exp);
    int cyc;
    cyc = 0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    while (sb.size() != 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    #1 bus.out_ready = 1'b0;
    chk("drain_cycles", 32'(cyc), 32'(n_exp));
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    bus.new_number = 1'b1;
    bus.x = '0;
    bus.y = '0;
    bus.out_ready = 1'b0;
    clear_ovf = 1'b0;
    reset = 1'b0;

    // Reset values, then strobe held high across release must not capture.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);
    chk("rst_out_x", 32'(bus.out_x), 32'd0);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("held_level", 32'(fifo_level), 32'd0);
    chk("held_count", 32'(sample_count), 32'd0);
    chk("held_valid", 32'(bus.out_valid), 32'd0);
    bus.new_number = 1'b0;
    repeat (4) @(posedge clk);

    // Single capture latency: out_valid rises after the third edge.
    @(posedge clk);
    #1;
    bus.x = 16'd1;
    bus.y = 16'd5;
    bus.new_number = 1'b1;
    sb.push_back('{x: 16'd1, y: 16'd5});
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_valid_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_x", 32'(bus.out_x), 32'd1);
    chk("lat_out_y", 32'(bus.out_y), 32'd5);
    chk("lat_level", 32'(fifo_level), 32'd1);
    repeat (17) @(posedge clk);
    #1 bus.new_number = 1'b0;
    chk("one_push_level", 32'(fifo_level), 32'd1);
    chk("one_push_count", 32'(sample_count), 32'd1);
    repeat (4) @(posedge clk);
    drain(1);

    // Fill to DEPTH, fifth capture drops; drain back to back.
    reset_dut();
    for (int i = 0; i < 5; i++) strobe(t3x[i], t3y[i], i < 4);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_count", 32'(sample_count), 32'd4);
    drain(4);
    chk("hold_out_x", 32'(bus.out_x), 32'd4);
    chk("hold_out_y", 32'(bus.out_y), 32'd20);

    // Full FIFO, capture coincident with a pop: accepted, level stays 4.
    reset_dut();
    for (int i = 0; i < 4; i++) strobe(16'(10 + i), 16'(100 + i), 1'b1);
    chk("fill_level", 32'(fifo_level), 32'd4);
    @(posedge clk);
    #1;
    bus.x = 16'd14;
    bus.y = 16'd104;
    bus.new_number = 1'b1;
    sb.push_back('{x: 16'd14, y: 16'd104});
    @(posedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk("coinc_level", 32'(fifo_level), 32'd4);
    chk("coinc_ovf", 32'(overflow), 32'd0);
    chk("coinc_count", 32'(sample_count), 32'd5);
    repeat (2) @(posedge clk);
    #1 bus.new_number = 1'b0;
    repeat (4) @(posedge clk);

    // Drop sets overflow; drop with clear_ovf in the same cycle keeps it set.
    strobe(16'd20, 16'd200, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_level", 32'(fifo_level), 32'd4);
    @(posedge clk);
    #1;
    bus.x = 16'd21;
    bus.y = 16'd210;
    bus.new_number = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);
    bus.new_number = 1'b0;
    repeat (4) @(posedge clk);
    chk("drop_count", 32'(sample_count), 32'd5);
    drain(4);

    // Duplicate x back to back: filtered only when the option is built in.
    reset_dut();
    strobe(16'd2, 16'd10, 1'b1);
`ifdef SAMPLE_INGRESS_DUP_FILTER_EN
    strobe(16'd2, 16'd11, 1'b0);
    chk("dup_count", 32'(sample_count), 32'd1);
    chk("dup_level", 32'(fifo_level), 32'd1);
    chk("dup_ovf", 32'(overflow), 32'd0);
    drain(1);
`else
    strobe(16'd2, 16'd11, 1'b1);
    chk("dup_count", 32'(sample_count), 32'd2);
    chk("dup_level", 32'(fifo_level), 32'd2);
    chk("dup_ovf", 32'(overflow), 32'd0);
    drain(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
